// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared types and constants for the IF/ID buffer.
package if_id_buffer_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;

endpackage

// File: rtl/if_id_buffer_slot.sv
// rtl/if_id_buffer_slot.sv - ifid_slot: one load-enabled entry register with async reset.
module ifid_slot
  import if_id_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  ifid_entry_t data_in,
  output ifid_entry_t data_out
);

  ifid_entry_t data_q;
  ifid_entry_t data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q.pc    <= 32'h0;
      data_q.instr <= RESET_INSTR;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID pipeline buffer; IFID_SKID_EN selects 2-entry skid, else single entry.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic [24:0] dec_imm_field,
  output logic [6:0]  dec_opcode
);

  buf_state_e  state_q;
  buf_state_e  state_d;
  ifid_entry_t fetch_entry;
  ifid_entry_t head_in;
  ifid_entry_t head;
  logic        head_load;
  logic        push;
  logic        pop;

  assign dec_valid   = (state_q != ST_EMPTY);
  assign fetch_entry = '{pc: fetch_pc, instr: fetch_instr};
  assign push        = fetch_valid & fetch_ready;
  assign pop         = dec_valid & dec_ready;

`ifdef IFID_SKID_EN
  ifid_entry_t tail;
  logic        tail_load;
  logic        head_from_tail;

  assign fetch_ready = (state_q != ST_TWO);
  assign head_in     = head_from_tail ? tail : fetch_entry;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    tail_load      = 1'b0;
    head_from_tail = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) begin head_load = 1'b1; state_d = ST_ONE; end
        ST_ONE: begin
          // push+pop replaces the head in place; push alone parks in the tail
          if (push && pop)  head_load = 1'b1;
          else if (push)    begin tail_load = 1'b1; state_d = ST_TWO; end
          else if (pop)     state_d = ST_EMPTY;
        end
        ST_TWO: if (pop) begin head_load = 1'b1; head_from_tail = 1'b1; state_d = ST_ONE; end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  ifid_slot #(.RESET_INSTR(NOP_INSTR)) u_tail (
    .clock(clock), .reset(reset), .load(tail_load), .data_in(fetch_entry), .data_out(tail)
  );
`else
  assign fetch_ready = !dec_valid | dec_ready;
  assign head_in     = fetch_entry;

  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) begin head_load = 1'b1; state_d = ST_ONE; end
        ST_ONE: begin
          if (push)     head_load = 1'b1;
          else if (pop) state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
`endif

  ifid_slot #(.RESET_INSTR(NOP_INSTR)) u_head (
    .clock(clock), .reset(reset), .load(head_load), .data_in(head_in), .data_out(head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // stale slot contents are masked so an empty buffer always shows a NOP at pc 0
  assign dec_pc        = dec_valid ? head.pc    : 32'h0;
  assign dec_instr     = dec_valid ? head.instr : NOP_INSTR;
  assign dec_imm_field = dec_instr[31:7];
  assign dec_opcode    = dec_instr[6:0];

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - scoreboard bench for if_id_buffer (either IFID_SKID_EN build).
`timescale 1ns/1ps
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instr = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [24:0] dec_imm_field;
  logic [6:0]  dec_opcode;

  if_id_buffer dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_imm_field(dec_imm_field), .dec_opcode(dec_opcode)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented head against the model queue, pops on handshake.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() == 0) begin
        chk("idle_valid", {31'b0, dec_valid}, 32'd0);
        chk("idle_instr", dec_instr, NOP);
        chk("idle_pc", dec_pc, 32'd0);
        chk("idle_imm", {7'b0, dec_imm_field}, {7'b0, NOP[31:7]});
        chk("idle_opcode", {25'b0, dec_opcode}, {25'b0, NOP[6:0]});
      end else begin
        chk("head_valid", {31'b0, dec_valid}, 32'd1);
        chk("head_pc", dec_pc, exp_q[0].pc);
        chk("head_instr", dec_instr, exp_q[0].instr);
        chk("head_imm", {7'b0, dec_imm_field}, exp_q[0].instr >> 7);
        chk("head_opcode", {25'b0, dec_opcode}, exp_q[0].instr & 32'h7f);
        if (dec_ready && !flush && !reset) void'(exp_q.pop_front());
      end
    end
  end

  // Stimulus: one cycle of inputs; the model accepts an offer when there is room.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic dr, input logic fl);
    logic exp_ready;
    @(negedge clock);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    dec_ready   = dr;
    flush       = fl;
    #1;
    exp_ready = (exp_q.size() < CAP) || (CAP == 1 && dr);
    chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, exp_ready});
    #2;
    if (fl) exp_q.delete();
    else if (fv && exp_ready) exp_q.push_back('{pc: pc, instr: ins});
  endtask

  task automatic mid_reset();
    @(negedge clock);
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
    flush       = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_instr", dec_instr, NOP);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_ready", {31'b0, fetch_ready}, 32'd1);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("por_valid", {31'b0, dec_valid}, 32'd0);
    chk("por_instr", dec_instr, NOP);
    chk("por_pc", dec_pc, 32'd0);
    chk("por_ready", {31'b0, fetch_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;

    // single push, decode stalled
    drive(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("imm_addi", {7'b0, dec_imm_field}, 32'h0000_A001);
    chk("opcode_addi", {25'b0, dec_opcode}, 32'h13);

    // second push while stalled, then drain two entries
    drive(1'b1, 32'h104, 32'h0010_0113, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // push and pop in the same cycle from a single entry
    drive(1'b1, 32'h100, 32'h0000_0033, 1'b0, 1'b0);
    drive(1'b1, 32'h108, 32'h0020_0193, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // flush beats a simultaneous offer
    drive(1'b1, 32'h10c, 32'h0030_0213, 1'b0, 1'b0);
    drive(1'b1, 32'h200, 32'h0040_0293, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // asynchronous reset with entries in flight
    drive(1'b1, 32'h300, 32'h1111_1113, 1'b0, 1'b0);
    drive(1'b1, 32'h304, 32'h2222_2213, 1'b0, 1'b0);
    mid_reset();
    drive(1'b1, 32'h400, 32'h3333_3313, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 4) != 0, {$urandom_range(0, 16'hffff), 2'b00} , $urandom,
            ($urandom % 3) != 0, ($urandom % 32) == 0);
    end

    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
